// File: rtl/mem_arb_multi.sv
// N-channel burst arbiter: round-robin or fixed-priority selection of cache/DMA
// clients onto a single burst-capable main-memory port.

module mem_arb_lane (
    input  logic granted,
    input  logic cmd_phase,
    input  logic data_phase,
    input  logic mm_waitrequest,
    input  logic mm_rd_valid,
    output logic waitrequest,
    output logic rd_valid
);
    // Only the granted lane ever sees memory back-pressure or read beats.
    assign waitrequest = (granted && cmd_phase) ? mm_waitrequest : 1'b1;
    assign rd_valid    = granted && data_phase && mm_rd_valid;
endmodule

module mem_arb_multi #(
    parameter int NCHAN          = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BURSTLEN_WIDTH = 3,
    parameter int RR_MODE        = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NCHAN*ADDR_WIDTH-1:0]      c_addr,
    input  logic [NCHAN*BURSTLEN_WIDTH-1:0]  c_burst_len,
    input  logic [NCHAN*DATA_WIDTH-1:0]      c_wr_data,
    input  logic [NCHAN-1:0]                 c_wr,
    input  logic [NCHAN-1:0]                 c_rd,
    output logic [NCHAN-1:0]                 c_waitrequest,
    output logic [DATA_WIDTH-1:0]            c_rd_data,
    output logic [NCHAN-1:0]                 c_rd_valid,
    output logic [ADDR_WIDTH-1:0]            mm_addr,
    output logic [BURSTLEN_WIDTH-1:0]        mm_burst_len,
    output logic [DATA_WIDTH-1:0]            mm_data_out,
    output logic                             mm_wr,
    output logic                             mm_rd,
    input  logic                             mm_waitrequest,
    input  logic [DATA_WIDTH-1:0]            mm_data_in,
    input  logic                             mm_rd_valid
);
    localparam int CW = $clog2(NCHAN);

    typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR_DATA} state_t;

    state_t                    state, state_nxt;
    logic [CW-1:0]             grant, grant_nxt, rr_ptr, rr_nxt, winner, grant_inc;
    logic [BURSTLEN_WIDTH-1:0] beat_cnt, beat_nxt;
    logic [NCHAN-1:0]          req;
    logic                      found;
    logic [CW:0]               idx;

    logic [NCHAN-1:0][ADDR_WIDTH-1:0]     addr_a;
    logic [NCHAN-1:0][BURSTLEN_WIDTH-1:0] blen_a;
    logic [NCHAN-1:0][DATA_WIDTH-1:0]     wdata_a;

    assign addr_a    = c_addr;
    assign blen_a    = c_burst_len;
    assign wdata_a   = c_wr_data;
    assign req       = c_rd | c_wr;
    assign grant_inc = (grant == CW'(NCHAN - 1)) ? '0 : grant + CW'(1);
    assign c_rd_data = mm_data_in;

    // Scan starts at rr_ptr (RR) or at 0 (fixed); first requester found wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NCHAN; k++) begin
            idx = (RR_MODE != 0) ? {1'b0, rr_ptr} + (CW+1)'(k) : (CW+1)'(k);
            if (idx >= (CW+1)'(NCHAN))
                idx = idx - (CW+1)'(NCHAN);
            if (!found && req[idx[CW-1:0]]) begin
                found  = 1'b1;
                winner = idx[CW-1:0];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            beat_cnt <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            beat_cnt <= beat_nxt;
            rr_ptr   <= rr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        beat_nxt     = beat_cnt;
        rr_nxt       = rr_ptr;
        mm_rd        = 1'b0;
        mm_wr        = 1'b0;
        mm_addr      = '0;
        mm_burst_len = '0;
        mm_data_out  = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt = winner;
                    beat_nxt  = blen_a[winner];
                    state_nxt = c_wr[winner] ? WR_DATA : RD_CMD;
                end
            end
            RD_CMD: begin
                mm_rd        = 1'b1;
                mm_addr      = addr_a[grant];
                mm_burst_len = blen_a[grant];
                if (!mm_waitrequest)
                    state_nxt = RD_DATA;
            end
            RD_DATA: begin
                if (mm_rd_valid) begin
                    if (beat_cnt == '0) begin
                        state_nxt = IDLE;
                        rr_nxt    = grant_inc;
                    end else begin
                        beat_nxt = beat_cnt - 1'b1;
                    end
                end
            end
            WR_DATA: begin
                // A client dropping c_wr mid-burst stalls the burst rather than aborting it.
                mm_wr        = c_wr[grant];
                mm_addr      = addr_a[grant];
                mm_burst_len = blen_a[grant];
                mm_data_out  = wdata_a[grant];
                if (c_wr[grant] && !mm_waitrequest) begin
                    if (beat_cnt == '0) begin
                        state_nxt = IDLE;
                        rr_nxt    = grant_inc;
                    end else begin
                        beat_nxt = beat_cnt - 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    for (genvar i = 0; i < NCHAN; i++) begin : g_lane
        mem_arb_lane u_lane (
            .granted        (grant == CW'(i)),
            .cmd_phase      ((state == RD_CMD) || (state == WR_DATA)),
            .data_phase     (state == RD_DATA),
            .mm_waitrequest (mm_waitrequest),
            .mm_rd_valid    (mm_rd_valid),
            .waitrequest    (c_waitrequest[i]),
            .rd_valid       (c_rd_valid[i])
        );
    end
endmodule

// File: tb/tb_mem_arb_multi.sv
// Randomised bench for mem_arb_multi: client/memory models plus a queue-based
// round-robin order predictor; a fixed-priority twin shares the inputs.

module tb_mem_arb_multi;
    localparam int N = 4, AW = 32, DW = 32, BW = 3;
    localparam int OP_RD = 0, OP_WR = 1, OP_BOTH = 2;

    logic clock = 1'b0;
    logic reset;
    logic [N*AW-1:0] c_addr;
    logic [N*BW-1:0] c_burst_len;
    logic [N*DW-1:0] c_wr_data;
    logic [N-1:0]    c_wr, c_rd, c_waitrequest, c_rd_valid;
    logic [DW-1:0]   c_rd_data, mm_data_out, mm_data_in;
    logic [AW-1:0]   mm_addr;
    logic [BW-1:0]   mm_burst_len;
    logic            mm_wr, mm_rd, mm_waitrequest, mm_rd_valid;

    logic [N-1:0]    f_wait, f_rdv;
    logic [DW-1:0]   f_rdata, f_dout;
    logic [AW-1:0]   f_addr;
    logic [BW-1:0]   f_blen;
    logic            f_wr, f_rd;

    always #5 clock = ~clock;

    mem_arb_multi #(.NCHAN(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTLEN_WIDTH(BW), .RR_MODE(1)) dut (
        .clock(clock), .reset(reset), .c_addr(c_addr), .c_burst_len(c_burst_len),
        .c_wr_data(c_wr_data), .c_wr(c_wr), .c_rd(c_rd), .c_waitrequest(c_waitrequest),
        .c_rd_data(c_rd_data), .c_rd_valid(c_rd_valid), .mm_addr(mm_addr),
        .mm_burst_len(mm_burst_len), .mm_data_out(mm_data_out), .mm_wr(mm_wr), .mm_rd(mm_rd),
        .mm_waitrequest(mm_waitrequest), .mm_data_in(mm_data_in), .mm_rd_valid(mm_rd_valid));

    mem_arb_multi #(.NCHAN(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTLEN_WIDTH(BW), .RR_MODE(0)) dut_fix (
        .clock(clock), .reset(reset), .c_addr(c_addr), .c_burst_len(c_burst_len),
        .c_wr_data(c_wr_data), .c_wr(c_wr), .c_rd(c_rd), .c_waitrequest(f_wait),
        .c_rd_data(f_rdata), .c_rd_valid(f_rdv), .mm_addr(f_addr),
        .mm_burst_len(f_blen), .mm_data_out(f_dout), .mm_wr(f_wr), .mm_rd(f_rd),
        .mm_waitrequest(mm_waitrequest), .mm_data_in(mm_data_in), .mm_rd_valid(mm_rd_valid));

    // client model state
    logic [AW-1:0] t_addr  [N];
    logic [BW-1:0] t_blen  [N];
    logic [DW-1:0] t_wbase [N];
    int            t_beat  [N];
    logic          t_rd [N], t_wr [N];
    bit            t_act [N], t_started [N];

    always_comb begin
        c_addr = '0; c_burst_len = '0; c_wr_data = '0; c_rd = '0; c_wr = '0;
        for (int i = 0; i < N; i++) begin
            c_addr[i*AW +: AW]      = t_addr[i];
            c_burst_len[i*BW +: BW] = t_blen[i];
            c_wr_data[i*DW +: DW]   = t_wbase[i] + DW'(t_beat[i]);
            c_rd[i]                 = t_rd[i];
            c_wr[i]                 = t_wr[i];
        end
    end

    int n_tests = 0, n_fail = 0;
    int rd_pend, rd_beat, wait_pct, gap_pct, cyc, first_rd_cyc, last_start, model_ptr, cur;
    int n_mmrd, n_wrbeats;
    int rd_beats_ch [N];
    bit stray_en;
    logic [AW-1:0] rd_addr;
    bit            wait_seq [$];
    int            exp_q [$];
    logic [DW-1:0] wr_log [$];

    logic [N-1:0]  s_wait, s_rdv, s_rdv_f;
    logic [DW-1:0] s_rdata, s_dout;
    logic [AW-1:0] s_addr;
    logic [BW-1:0] s_blen;
    bit            s_ev_rdcmd, s_ev_wr, s_ev_rdbeat;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(logic [AW-1:0] a, int b);
        return DW'(a * 3 + AW'(b)) ^ 32'hC0DE_0000;
    endfunction

    function automatic int oh2i(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit any_active();
        for (int i = 0; i < N; i++) if (t_act[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_clients();
        for (int i = 0; i < N; i++) begin
            t_addr[i] = '0; t_blen[i] = '0; t_wbase[i] = '0; t_beat[i] = 0;
            t_rd[i] = 1'b0; t_wr[i] = 1'b0; t_act[i] = 1'b0; t_started[i] = 1'b0;
        end
    endtask

    task automatic chk_reset_vals();
        check("rst_mm_rd", mm_rd, 0);
        check("rst_mm_wr", mm_wr, 0);
        check("rst_wait", c_waitrequest, 4'hF);
        check("rst_rdv", c_rd_valid, 0);
        check("rst_addr", {mm_addr, mm_burst_len}, 0);
        check("rst_dout", mm_data_out, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; mm_rd_valid = 1'b0; mm_waitrequest = 1'b0;
        clear_clients();
        rd_pend = 0; model_ptr = 0;
        exp_q.delete(); wait_seq.delete();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // One clock: memory model drives, outputs sampled at negedge, model updated after posedge.
    task automatic cycle();
        if (wait_seq.size() > 0) mm_waitrequest = wait_seq.pop_front();
        else mm_waitrequest = ($urandom_range(99) < wait_pct);
        if (rd_pend > 0) begin
            mm_rd_valid = ($urandom_range(99) >= gap_pct);
            mm_data_in  = mem_word(rd_addr, rd_beat);
        end else begin
            mm_rd_valid = stray_en && ($urandom_range(3) == 0);
            mm_data_in  = $urandom;
        end
        @(negedge clock);
        s_wait = c_waitrequest; s_rdv = c_rd_valid; s_rdv_f = f_rdv; s_rdata = c_rd_data;
        s_addr = mm_addr; s_blen = mm_burst_len; s_dout = mm_data_out;
        s_ev_rdcmd  = mm_rd && !mm_waitrequest;
        s_ev_wr     = mm_wr && !mm_waitrequest;
        s_ev_rdbeat = (rd_pend > 0) && mm_rd_valid;
        if (mm_rd) begin
            n_mmrd++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
        end
        check("wait_onehot", $countones(~c_waitrequest) <= 1, 1);
        if (!s_ev_rdbeat) check("no_valid", c_rd_valid, 0);
        @(posedge clock);
        if (s_ev_rdcmd) begin
            rd_pend = int'(s_blen) + 1; rd_addr = s_addr; rd_beat = 0;
        end else if (s_ev_rdbeat) begin
            rd_pend--; rd_beat++;
        end
        cyc++;
        #1;
    endtask

    task automatic finish_client(int ch);
        t_rd[ch] = 1'b0; t_wr[ch] = 1'b0; t_act[ch] = 1'b0;
    endtask

    task automatic client_step();
        int ch, e;
        ch = oh2i(~s_wait);
        if (s_ev_rdcmd || s_ev_wr) begin
            if (ch < 0) check("grant_vis", 0, 1);
            else begin
                if (!t_started[ch]) begin
                    t_started[ch] = 1'b1;
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 99;
                    check("order", ch, e);
                    cur = ch;
                end
                check("cmd_addr", s_addr, t_addr[ch]);
                check("cmd_blen", s_blen, t_blen[ch]);
                if (s_ev_rdcmd) check("rd_on_wr", t_wr[ch], 0);
                if (s_ev_wr) begin
                    check("wr_data", s_dout, t_wbase[ch] + DW'(t_beat[ch]));
                    wr_log.push_back(s_dout);
                    n_wrbeats++;
                    t_beat[ch]++;
                    if (t_beat[ch] > int'(t_blen[ch])) finish_client(ch);
                end
            end
        end
        if (s_ev_rdbeat) begin
            check("rd_route", s_rdv, 1 << cur);
            check("rd_data", s_rdata, mem_word(t_addr[cur], t_beat[cur]));
            rd_beats_ch[cur]++;
            t_beat[cur]++;
            if (t_beat[cur] > int'(t_blen[cur])) finish_client(cur);
        end
    endtask

    task automatic add_client(int ch, int op, int blen, logic [AW-1:0] addr, logic [DW-1:0] wbase);
        t_addr[ch] = addr; t_blen[ch] = BW'(blen); t_wbase[ch] = wbase; t_beat[ch] = 0;
        t_rd[ch] = (op != OP_WR); t_wr[ch] = (op != OP_RD);
        t_act[ch] = 1'b1; t_started[ch] = 1'b0;
    endtask

    // Reference: serve pending clients one at a time, next = first pending at/after pointer.
    task automatic plan();
        bit pend [N];
        int p, idx;
        bit hit;
        p = model_ptr;
        for (int i = 0; i < N; i++) pend[i] = t_act[i] && !t_started[i];
        for (int n = 0; n < N; n++) begin
            hit = 1'b0;
            for (int k = 0; k < N; k++) begin
                idx = (p + k) % N;
                if (!hit && pend[idx]) begin
                    hit = 1'b1; pend[idx] = 1'b0; exp_q.push_back(idx); p = (idx + 1) % N;
                end
            end
        end
        model_ptr = p;
    endtask

    task automatic launch();
        int guard;
        plan();
        last_start = cyc; first_rd_cyc = -1; guard = 0;
        while (any_active() && guard < 600) begin
            cycle(); client_step(); guard++;
        end
        if (any_active()) begin
            check("timeout", 1, 0);
            do_reset();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seq_rr [$];
        int seq_fx [$];
        int g;
        reset = 1'b1; mm_waitrequest = 1'b0; mm_rd_valid = 1'b0; mm_data_in = '0;
        clear_clients();
        rd_pend = 0; rd_beat = 0; rd_addr = '0; wait_pct = 0; gap_pct = 0; stray_en = 1'b0;
        cyc = 0; first_rd_cyc = -1; model_ptr = 0; cur = 0; n_mmrd = 0; n_wrbeats = 0;
        for (int i = 0; i < N; i++) rd_beats_ch[i] = 0;
        repeat (2) @(posedge clock);
        #1 chk_reset_vals();
        reset = 1'b0;

        // single read ch2, 4 beats, no back-pressure
        n_mmrd = 0;
        add_client(2, OP_RD, 3, 32'h1000_0040, '0);
        launch();
        check("t2_mmrd_cycles", n_mmrd, 1);
        check("t2_latency", first_rd_cyc - last_start, 1);
        check("t2_beats_ch2", rd_beats_ch[2], 4);
        check("t2_beats_other", rd_beats_ch[0] + rd_beats_ch[1] + rd_beats_ch[3], 0);
        cycle();
        check("t2_idle_wait", s_wait, 4'hF);

        // write ch0, 2 beats, waitrequest held on beat 0 for two cycles
        wr_log.delete();
        wait_seq.push_back(1'b0); wait_seq.push_back(1'b1); wait_seq.push_back(1'b1);
        add_client(0, OP_WR, 1, 32'h2000_0000, 32'hA5A5_0000);
        launch();
        check("t3_nbeats", wr_log.size(), 2);
        check("t3_beat0", wr_log[0], 32'hA5A5_0000);
        check("t3_beat1", wr_log[1], 32'hA5A5_0001);

        // ch1 rd+wr together: write wins
        n_mmrd = 0; n_wrbeats = 0;
        add_client(1, OP_BOTH, 2, 32'h3000_0100, 32'h1234_0000);
        launch();
        check("t4_no_mmrd", n_mmrd, 0);
        check("t4_wr_beats", n_wrbeats, 3);

        // all channels reading continuously: RR and fixed-priority twin in lockstep
        do_reset();
        for (int i = 0; i < N; i++) begin
            t_rd[i] = 1'b1; t_addr[i] = AW'(32'h4000_0000 + i * 16);
        end
        g = 0;
        while (seq_rr.size() < 5 && g < 80) begin
            cycle();
            if (s_rdv != '0) seq_rr.push_back(oh2i(s_rdv));
            if (s_rdv_f != '0) seq_fx.push_back(oh2i(s_rdv_f));
            g++;
        end
        check("t5_done", seq_rr.size() >= 5, 1);
        for (int k = 0; k < 5; k++) begin
            check("t5_rr_order", seq_rr[k], k % N);
            check("t5_fix_order", seq_fx[k], 0);
        end
        do_reset();

        // reset during beat 2 of an 8-beat read
        add_client(3, OP_RD, 7, 32'h5000_0000, '0);
        plan();
        g = 0;
        while (t_beat[3] < 2 && g < 100) begin
            cycle(); client_step(); g++;
        end
        check("t6_reach_beat2", t_beat[3], 2);
        mm_rd_valid = 1'b1; mm_waitrequest = 1'b0;
        #1 check("t6_pre_route", c_rd_valid, 4'b1000);
        reset = 1'b1;
        #1 chk_reset_vals();
        do_reset();
        for (int i = 0; i < N; i++) rd_beats_ch[i] = 0;
        add_client(3, OP_RD, 1, 32'h5000_0100, '0);
        launch();
        check("t6_after_beats", rd_beats_ch[3], 2);

        // stray read valids while idle
        stray_en = 1'b1;
        repeat (12) cycle();

        // randomised batches with back-pressure, read gaps and stray valids
        wait_pct = 30; gap_pct = 30;
        for (int b = 0; b < 40; b++) begin
            int mask;
            mask = $urandom_range(15, 1);
            for (int i = 0; i < N; i++)
                if (mask[i]) add_client(i, $urandom_range(2), $urandom_range(7), $urandom, $urandom);
            launch();
        end
        check("rand_exp_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
